// File: rtl/spk_event_scanner.sv
// Reads spike words from a registered-read BRAM and emits one valid/ready event per set bit,
// lowest neuron index first. Zero words cost three cycles. Events are never emitted for them.
module spk_event_scanner #(
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int IDX_WIDTH      = $clog2(RAM_DEPTH*RAM_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [RAM_ADDR_WIDTH:0]   num_words,
  output logic                      ren,
  output logic [RAM_ADDR_WIDTH-1:0] raddr,
  input  logic [RAM_WIDTH-1:0]      rdat,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [IDX_WIDTH-1:0]      ev_idx,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_WIDTH:0]        spk_count
);

  localparam int BW = $clog2(RAM_WIDTH);

  // Stream handshake: an event transfers on a rising clk edge where ev_valid and ev_ready are both
  // 1. Once raised, ev_valid and ev_idx hold until that transfer. ev_ready is ignored otherwise.

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_SCAN, S_DONE} state_t;

  state_t                    state, state_next;
  logic [RAM_ADDR_WIDTH-1:0] ptr;
  logic [RAM_ADDR_WIDTH:0]   nwords;
  logic [RAM_ADDR_WIDTH:0]   num_clamped;
  logic [RAM_WIDTH-1:0]      word_reg;
  logic [RAM_WIDTH-1:0]      word_rem;
  logic                      fire;
  logic                      last_word;
  logic                      word_end;

  function automatic logic [IDX_WIDTH-1:0] event_index(input logic [RAM_ADDR_WIDTH-1:0] p,
                                                       input logic [RAM_WIDTH-1:0] w);
    logic [BW-1:0] b;
    b = '0;
    for (int i = RAM_WIDTH - 1; i >= 0; i--) begin
      if (w[i]) b = BW'(i);
    end
    return IDX_WIDTH'(p) * IDX_WIDTH'(RAM_WIDTH) + IDX_WIDTH'(b);
  endfunction

  assign num_clamped = (num_words > (RAM_ADDR_WIDTH+1)'(RAM_DEPTH)) ?
                       (RAM_ADDR_WIDTH+1)'(RAM_DEPTH) : num_words;
  assign fire        = ev_valid & ev_ready;
  assign word_rem    = word_reg & (word_reg - RAM_WIDTH'(1));
  assign last_word   = ({1'b0, ptr} == (nwords - (RAM_ADDR_WIDTH+1)'(1)));
  // ev_valid is low in SCAN only when the fetched word was empty
  assign word_end    = !ev_valid || (fire && (word_rem == '0));

  assign ren   = (state == S_FETCH);
  assign raddr = ptr;
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (num_clamped == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_next = S_LATCH;
      S_LATCH: state_next = S_SCAN;
      S_SCAN:  if (word_end) state_next = last_word ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      nwords    <= '0;
      word_reg  <= '0;
      ev_valid  <= 1'b0;
      ev_idx    <= '0;
      spk_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            nwords    <= num_clamped;
            ptr       <= '0;
            spk_count <= '0;
          end
        end
        S_LATCH: begin
          word_reg <= rdat;
          ev_valid <= (rdat != '0);
          ev_idx   <= event_index(ptr, rdat);
        end
        S_SCAN: begin
          if (fire) begin
            word_reg  <= word_rem;
            spk_count <= spk_count + (IDX_WIDTH+1)'(1);
            ev_valid  <= (word_rem != '0);
            if (word_rem != '0) ev_idx <= event_index(ptr, word_rem);
          end
          if (word_end && !last_word) ptr <= ptr + RAM_ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spk_event_scanner.sv
// Directed bench for spk_event_scanner: BRAM model, event/read logs and a handshake stability
// monitor, with immediate-assertion checks against hand-computed and model-derived values.
module tb_spk_event_scanner;

  localparam int DEPTH = 32;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int IW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_words;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [WIDTH-1:0] rdat;
  logic          ev_valid;
  logic          ev_ready;
  logic [IW-1:0] ev_idx;
  logic          busy;
  logic          done;
  logic [IW:0]   spk_count;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    exp_q[$];
  logic [IW-1:0]    got_q[$];
  logic [AW-1:0]    rd_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt, valid_cnt, hold_checks;
  logic          hold_pending = 1'b0;
  logic [IW-1:0] hold_idx;
  int cyc;

  spk_event_scanner dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .ren(ren), .raddr(raddr), .rdat(rdat),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_idx(ev_idx),
    .busy(busy), .done(done), .spk_count(spk_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ren) rdat <= mem[raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Monitor: sampled mid-cycle, describing what the next rising edge will do
  always @(negedge clk) begin
    if (hold_pending && !rst) begin
      hold_checks++;
      check("hold_valid", ev_valid, 1'b1);
      check("hold_idx", ev_idx, hold_idx);
    end
    hold_pending = ev_valid && !ev_ready && !rst;
    hold_idx     = ev_idx;
    if (!rst) begin
      if (ev_valid && ev_ready) got_q.push_back(ev_idx);
      if (ev_valid) valid_cnt++;
      if (ren) rd_q.push_back(raddr);
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete();
    rd_q.delete();
    exp_q.delete();
    done_cnt  = 0;
    valid_cnt = 0;
  endtask

  task automatic do_start(input logic [AW:0] n);
    start     = 1'b1;
    num_words = n;
    step();
    start     = 1'b0;
  endtask

  // mode 0: ready held 1, mode 1: ready toggles, other: random ready
  task automatic wait_done(input int mode, input int budget, output int c);
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      case (mode)
        0:       ev_ready = 1'b1;
        1:       ev_ready = ~ev_ready;
        default: ev_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      c++;
    end
    check("done_reached", done, 1'b1);
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_idx"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_words = '0; ev_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    step(); step();
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ren", ren, 1'b0);
    check("rst_raddr", raddr, '0);
    check("rst_ev_idx", ev_idx, '0);
    check("rst_spk_count", spk_count, '0);
    rst = 1'b0;
    step();

    // Two words, 0x5 and 0x8000_0000: events 0, 2, 63
    mem[0] = 32'h0000_0005; mem[1] = 32'h8000_0000;
    clear_logs();
    exp_q = '{10'd0, 10'd2, 10'd63};
    ev_ready = 1'b1;
    do_start(6'd2);
    check("basic_busy", busy, 1'b1);
    wait_done(0, 200, cyc);
    check("basic_cycles", cyc, 7);
    step();
    compare_events("basic");
    check("basic_spk_count", spk_count, 11'd3);
    check("basic_done_once", done_cnt, 1);
    check("basic_busy_after", busy, 1'b0);

    // Three empty words: no events, 3 cycles per word
    mem[0] = '0; mem[1] = '0; mem[2] = '0;
    clear_logs();
    do_start(6'd3);
    wait_done(0, 200, cyc);
    check("zero_cycles", cyc, 9);
    step();
    check("zero_valid_cycles", valid_cnt, 0);
    check("zero_reads", rd_q.size(), 3);
    check("zero_spk_count", spk_count, 11'd0);

    // Full word with ready toggling: 0..31 exactly once, index held while stalled
    mem[0] = 32'hFFFF_FFFF;
    clear_logs();
    for (int i = 0; i < 32; i++) exp_q.push_back(IW'(i));
    hold_checks = 0;
    ev_ready = 1'b0;
    do_start(6'd1);
    wait_done(1, 500, cyc);
    step();
    compare_events("full");
    check("full_spk_count", spk_count, 11'd32);
    check("full_hold_seen", hold_checks > 0, 1'b1);

    // num_words = 0
    clear_logs();
    do_start(6'd0);
    check("nw0_done", done, 1'b1);
    step();
    check("nw0_reads", rd_q.size(), 0);
    check("nw0_spk_count", spk_count, 11'd0);
    check("nw0_busy", busy, 1'b0);

    // Start pulsed mid-scan, then again in the done cycle: both ignored
    mem[0] = 32'h0000_0005; mem[1] = 32'h8000_0000;
    clear_logs();
    exp_q = '{10'd0, 10'd2, 10'd63};
    ev_ready = 1'b1;
    do_start(6'd2);
    step(); step();
    do_start(6'd1);
    wait_done(0, 200, cyc);
    start = 1'b1; num_words = 6'd1;
    step();
    start = 1'b0;
    check("done_start_busy", busy, 1'b0);
    step();
    check("done_start_busy2", busy, 1'b0);
    compare_events("midstart");
    check("midstart_spk_count", spk_count, 11'd3);
    check("midstart_done_once", done_cnt, 1);

    // Reset in the middle of a SCAN of word 1
    mem[0] = 32'h0000_0001; mem[1] = 32'hFFFF_FFFF;
    clear_logs();
    ev_ready = 1'b1;
    do_start(6'd2);
    for (int i = 0; i < 6; i++) step();
    check("pre_rst_spk_count", spk_count, 11'd2);
    check("pre_rst_ev_idx", ev_idx, 10'd33);
    check("pre_rst_raddr", raddr, 5'd1);
    rst = 1'b1;
    step();
    check("mid_rst_ev_valid", ev_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_ren", ren, 1'b0);
    check("mid_rst_raddr", raddr, '0);
    check("mid_rst_ev_idx", ev_idx, '0);
    check("mid_rst_spk_count", spk_count, '0);
    rst = 1'b0;
    step();

    // Clamped num_words=40 over random sparse memory with random ready
    for (int i = 0; i < DEPTH; i++)
      mem[i] = (i % 5 == 0) ? '0 : ($urandom() & $urandom() & $urandom());
    clear_logs();
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < WIDTH; b++)
        if (mem[w][b]) exp_q.push_back(IW'(w * WIDTH + b));
    do_start(6'd40);
    wait_done(2, 6000, cyc);
    step();
    compare_events("rand");
    check("rand_spk_count", spk_count, exp_q.size());
    check("clamp_reads", rd_q.size(), 32);
    for (int i = 0; i < 32 && i < rd_q.size(); i++)
      check("clamp_raddr", rd_q[i], i);
    check("rand_busy_after", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
